// File: rtl/fifo_pkg.sv
// Shared defaults and mode encodings for the programmable FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_D_W   = 8;
  localparam int unsigned FIFO_AD_W  = 4;
  localparam int unsigned FIFO_DEPTH = 2 ** FIFO_AD_W;
  localparam int unsigned FIFO_AF_TH = FIFO_DEPTH - 2;
  localparam int unsigned FIFO_AE_TH = 2;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage: register array, one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned D_W  = FIFO_D_W,
  parameter int unsigned AD_W = FIFO_AD_W
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AD_W-1:0] wr_addr,
  input  logic [D_W-1:0]  wr_data,
  input  logic [AD_W-1:0] rd_addr,
  output logic [D_W-1:0]  rd_data
);

  localparam int unsigned DEPTH = 2 ** AD_W;

  logic [D_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : fifo_mem

// File: rtl/fifo_prog.sv
// Synchronous FIFO with occupancy count, programmable almost flags, sticky
// error flags and standard or first-word-fall-through read mode.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned D_W   = FIFO_D_W,
  parameter int unsigned AD_W  = FIFO_AD_W,
  parameter int unsigned AF_TH = (2 ** AD_W) - 2,
  parameter int unsigned AE_TH = FIFO_AE_TH,
  parameter int unsigned FWFT  = FIFO_STD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write,
  input  logic            read,
  input  logic [D_W-1:0]  data_in,
  output logic [D_W-1:0]  data_out,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [AD_W:0]   count,
  output logic            overflow,
  output logic            underflow
);

  localparam int unsigned DEPTH = 2 ** AD_W;
  localparam int unsigned CW    = AD_W + 1;

  logic [AD_W-1:0] wr_ptr;
  logic [AD_W-1:0] rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic [D_W-1:0]  rd_data;
  logic            wr_acc;
  logic            rd_acc;

  // Acceptance uses the registered flags only.
  assign wr_acc = write && !full;
  assign rd_acc = read && !empty;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - CW'(1);
    end
  end

  fifo_mem #(
    .D_W  (D_W),
    .AD_W (AD_W)
  ) u_mem (
    .clk     (clk),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Flags are registered from the next count so they track count exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AD_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AD_W'(1);
      end
      count        <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AF_TH));
      almost_empty <= (count_nxt <= CW'(AE_TH));
      overflow     <= overflow  | (write && full);
      underflow    <= underflow | (read && empty);
    end
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head word is presented directly; zero while nothing is stored.
      assign data_out = empty ? '0 : rd_data;
    end else begin : g_std
      logic [D_W-1:0] data_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q <= '0;
        end else if (rd_acc) begin
          data_q <= rd_data;
        end
      end

      assign data_out = data_q;
    end
  endgenerate

endmodule : fifo_prog

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench for fifo_prog in standard and FWFT modes.
module tb_fifo_prog;

  logic       clk;
  logic       rst;

  logic       s_write, s_read;
  logic [7:0] s_din, s_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0] s_count;

  logic       f_write, f_read;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  int n_checks;
  int n_fail;

  fifo_prog #(
    .D_W(8), .AD_W(4), .AF_TH(14), .AE_TH(2), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .write(s_write), .read(s_read), .data_in(s_din),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_prog #(
    .D_W(8), .AD_W(4), .AF_TH(14), .AE_TH(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .write(f_write), .read(f_read), .data_in(f_din),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_write = 0; s_read = 0; f_write = 0; f_read = 0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      s_write = 1; s_din = 8'(i + 1);
      tick();
    end
    s_write = 0;
    n_checks++;
    if (s_count !== 5'd9) begin
      n_fail++; $display("FAIL reset_precount: got %0d expected 9", s_count);
    end
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (s_count !== 5'd0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_full !== 1'b0 ||
        s_af !== 1'b0 || s_ovf !== 1'b0 || s_unf !== 1'b0 || s_dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: count=%0d empty=%b ae=%b full=%b af=%b ovf=%b unf=%b dout=%h expected 0 1 1 0 0 0 0 00",
               s_count, s_empty, s_ae, s_full, s_af, s_ovf, s_unf, s_dout);
    end
    n_checks++;
    if (f_dout !== 8'h00 || f_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_fwft: dout=%h empty=%b expected 00 1", f_dout, f_empty);
    end
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic fill_std(input int n);
    for (int k = 1; k <= n; k++) begin
      s_write = 1; s_din = 8'(k);
      tick();
    end
    s_write = 0;
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      s_write = 1; s_din = 8'(k);
      tick();
      n_checks++;
      if (s_count !== 5'(k) || s_ae !== (k <= 2) || s_af !== (k >= 14) ||
          s_full !== (k == 16) || s_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: count=%0d ae=%b af=%b full=%b empty=%b expected %0d %b %b %b 0",
                 k, s_count, s_ae, s_af, s_full, s_empty, k, (k <= 2), (k >= 14), (k == 16));
      end
    end
    s_din = 8'h11;
    tick();
    s_write = 0;
    n_checks++;
    if (s_ovf !== 1'b1 || s_count !== 5'd16 || s_unf !== 1'b0) begin
      n_fail++; $display("FAIL fill_overflow: ovf=%b count=%0d unf=%b expected 1 16 0", s_ovf, s_count, s_unf);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      s_read = 1;
      tick();
      n_checks++;
      if (s_dout !== 8'(i) || s_empty !== (i == 16) || s_count !== 5'(16 - i)) begin
        n_fail++;
        $display("FAIL drain_%0d: dout=%h empty=%b count=%0d expected %h %b %0d",
                 i, s_dout, s_empty, s_count, 8'(i), (i == 16), 16 - i);
      end
    end
    tick();
    s_read = 0;
    n_checks++;
    if (s_unf !== 1'b1 || s_dout !== 8'h10 || s_count !== 5'd0) begin
      n_fail++; $display("FAIL drain_underflow: unf=%b dout=%h count=%0d expected 1 10 0", s_unf, s_dout, s_count);
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s_write = 1; s_din = 8'(i);
      tick();
    end
    for (int j = 0; j < 40; j++) begin
      s_write = 1; s_read = 1; s_din = 8'(j + 5);
      tick();
      n_checks++;
      if (s_count !== 5'd5 || s_dout !== 8'(j)) begin
        n_fail++;
        $display("FAIL steady_%0d: count=%0d dout=%h expected 5 %h", j, s_count, s_dout, 8'(j));
      end
    end
    s_write = 0; s_read = 0;
    n_checks++;
    if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin
      n_fail++; $display("FAIL steady_errflags: ovf=%b unf=%b expected 0 0", s_ovf, s_unf);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    s_write = 1; s_read = 1; s_din = 8'h77;
    tick();
    s_write = 0; s_read = 0;
    n_checks++;
    if (s_count !== 5'd1 || s_unf !== 1'b1 || s_ovf !== 1'b0 || s_dout !== 8'h00) begin
      n_fail++; $display("FAIL simul_empty: count=%0d unf=%b ovf=%b dout=%h expected 1 1 0 00", s_count, s_unf, s_ovf, s_dout);
    end
    do_reset();
    fill_std(16);
    s_write = 1; s_read = 1; s_din = 8'hEE;
    tick();
    s_write = 0; s_read = 0;
    n_checks++;
    if (s_count !== 5'd15 || s_ovf !== 1'b1 || s_unf !== 1'b0 || s_dout !== 8'h01 || s_full !== 1'b0) begin
      n_fail++; $display("FAIL simul_full: count=%0d ovf=%b unf=%b dout=%h full=%b expected 15 1 0 01 0",
                         s_count, s_ovf, s_unf, s_dout, s_full);
    end
  endtask

  task automatic test_fwft();
    do_reset();
    f_write = 1; f_din = 8'hA5;
    tick();
    f_write = 0;
    n_checks++;
    if (f_dout !== 8'hA5 || f_empty !== 1'b0 || f_count !== 5'd1) begin
      n_fail++; $display("FAIL fwft_first: dout=%h empty=%b count=%0d expected a5 0 1", f_dout, f_empty, f_count);
    end
    f_write = 1; f_din = 8'h5A;
    tick();
    f_write = 0;
    n_checks++;
    if (f_dout !== 8'hA5 || f_count !== 5'd2) begin
      n_fail++; $display("FAIL fwft_hold: dout=%h count=%0d expected a5 2", f_dout, f_count);
    end
    f_read = 1;
    tick();
    n_checks++;
    if (f_dout !== 8'h5A || f_count !== 5'd1) begin
      n_fail++; $display("FAIL fwft_advance: dout=%h count=%0d expected 5a 1", f_dout, f_count);
    end
    tick();
    f_read = 0;
    n_checks++;
    if (f_dout !== 8'h00 || f_empty !== 1'b1 || f_unf !== 1'b0) begin
      n_fail++; $display("FAIL fwft_empty: dout=%h empty=%b unf=%b expected 00 1 0", f_dout, f_empty, f_unf);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0;
    s_write = 0; s_read = 0; s_din = '0;
    f_write = 0; f_read = 0; f_din = '0;
    tick();
    rst = 1'b1;
    tick();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_boundary();
    test_fwft();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_prog

// File: doc/fifo_prog.md
# fifo_prog

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through read mode. It replaces the fixed single-mode FIFO as the general buffering element between producer/consumer blocks in the single-clock datapath. It is a drop-in superset: the `write`/`read`/`full`/`empty`/`data_in`/`data_out` behaviour in standard mode is unchanged.

## Interface
- `D_W`, 8, data width in bits
- `AD_W`, 4, address width; depth `DEPTH = 2**AD_W`
- `AF_TH`, `DEPTH-2`, almost_full threshold; legal range 1..DEPTH
- `AE_TH`, 2, almost_empty threshold; legal range 0..DEPTH-1
- `FWFT`, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous assert, active-low; release is synchronous to `clk` by the system
- `write` in 1: push request
- `read` in 1: pop request
- `data_in` in D_W: push data
- `data_out` out D_W: read data
- `full` out 1: count == DEPTH
- `empty` out 1: count == 0
- `almost_full` out 1: count >= AF_TH
- `almost_empty` out 1: count <= AE_TH
- `count` out AD_W+1: occupancy, 0..DEPTH
- `overflow` out 1: sticky, write attempted while full
- `underflow` out 1: sticky, read attempted while empty

## Operation
- Write is accepted iff `write && !full`. On acceptance, `mem[wr_ptr] <= data_in` and `wr_ptr` increments.
- Read is accepted iff `read && !empty`. On acceptance, `rd_ptr` increments.
- Acceptance is evaluated on flag values sampled at the same edge. There is no read-through-full and no write-through-empty bypass.
- `count` logic:
  - +1 on write-only acceptance
  - -1 on read-only acceptance
  - unchanged when both or neither are accepted
- Pointers are AD_W bits and wrap modulo DEPTH naturally.
- All flags decode from the registered `count`. There is no combinational path from `read`/`write`/`data_in` to any flag.
- `overflow` sets on `write && full`; `underflow` sets on `read && empty`. Both are cleared only by `rst`. A rejected operation changes neither memory, pointers nor count.
- Standard mode (`FWFT=0`): `data_out <= mem[rd_ptr]` on accepted read. It holds its value otherwise, including on a rejected read.
- FWFT mode (`FWFT=1`): `data_out = mem[rd_ptr]` whenever `!empty`, and 0 when empty. An accepted read advances to the next word.
- Reset values: pointers 0; `count` 0; `empty` 1; `almost_empty` 1; `full` 0; `almost_full` 0; `overflow` 0; `underflow` 0; `data_out` 0. Memory contents are not reset.

## Timing
- Write latency: data written at edge N is readable at edge N+1. In FWFT mode, `data_out` is valid after edge N when the FIFO was empty.
- Standard read latency: 1 cycle. `data_out` updates on the edge that accepts `read`.
- Flags and `count` change on the edge following acceptance, never mid-cycle.
- `read` and `write` together while full: the read is accepted, the write is rejected, `overflow` sets, and `count` becomes DEPTH-1.
- `read` and `write` together while empty: the write is accepted, the read is rejected, `underflow` sets, and `count` becomes 1.
- `rst` asserted mid-operation forces all reset values immediately (asynchronously), regardless of `clk`.

## Structure
- Shared package/header `fifo_pkg` holds:
  - default `D_W`/`AD_W`
  - the derived `DEPTH` constant
  - threshold defaults
  - mode encodings `FIFO_STD=0`, `FIFO_FWFT=1`
- Sub-module `fifo_mem`: a DEPTH×D_W register array with one synchronous write port and one asynchronous read port at `rd_ptr`.
- `fifo_prog` contains the pointers, count, flag decode, error flags and output register/mux.

## Test plan
All scenarios use D_W=8, AD_W=4, AF_TH=14, AE_TH=2 unless stated.
- **Reset:** assert `rst`=0 mid-clock with count 9 -> all outputs at reset values within the same cycle; `empty`=1, `count`=0.
- **Fill:** write 0x01..0x10 on consecutive edges -> `almost_empty` drops after the 3rd write; `almost_full` rises after the 14th; `full` rises after the 16th with `count`=16. A 17th write of 0x11 -> `overflow`=1, `count` stays 16.
- **Drain (FWFT=0):** 16 consecutive reads -> `data_out` = 0x01..0x10, each one edge after acceptance; `empty`=1 after the 16th. A 17th read -> `underflow`=1, `data_out` holds 0x10.
- **Steady state:** at `count`=5, assert `read` and `write` together for 40 cycles with incrementing data -> `count` stays 5, output order is preserved across pointer wrap, and no error flags are set.
- **Boundary simultaneity:** simultaneous `read`/`write` at `count`=0 -> `count`=1 and `underflow`=1. At `count`=16 -> `count`=15 and `overflow`=1.
- **FWFT=1:** write 0xA5 into the empty FIFO -> `data_out`=0xA5 and `empty`=0 after that edge. Then write 0x5A and read once -> `data_out`=0x5A on the next edge; `data_out`=0 after the final read empties the FIFO.
